fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter ADDR_W, default 5: register-address width.
REQ-002 Parameter NUM_SRC, default 2: ID-stage source operands checked per cycle.
REQ-003 Parameter MC_LAT, default 4: EX occupancy in cycles of a multi-cycle op; legal range 2..15.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 id_valid  in  1  ID holds an instruction requesting issue.
REQ-007 id_rs  in  NUM_SRC*ADDR_W  source register addresses; source s occupies slice s.
REQ-008 id_rs_used  in  NUM_SRC  source s is actually read.
REQ-009 id_rd  in  ADDR_W  destination register.
REQ-010 id_wr_en  in  1  instruction writes id_rd.
REQ-011 id_is_load  in  1  result available only from MEM onward.
REQ-012 id_is_mc  in  1  multi-cycle EX op.
REQ-013 flush  in  1  synchronous kill of the ID and EX instructions.
REQ-014 fwd_sel  out  NUM_SRC*2  per source: 00 regfile, 01 EX, 10 MEM, 11 WB.
REQ-015 stall  out  1  ID must hold this cycle.
REQ-016 issue  out  1  ID instruction enters EX at the next edge.
REQ-017 busy  out  1  multi-cycle op occupies EX.
REQ-018 stall_cnt  out  16  saturating count of cycles with stall=1.

Function
REQ-019 The unit SHALL keep EX, MEM and WB tracking registers, each holding valid, rd, wr_en, is_load and is_mc.
REQ-020 A stage SHALL be a producer for source s only if valid, wr_en, id_rs_used[s], rs!=0 and rd==rs.
REQ-021 fwd_sel[s] SHALL select the youngest producer, priority EX > MEM > WB, else 00; the logic SHALL be combinational.
REQ-022 An EX producer with is_load or is_mc SHALL NOT be selected for forwarding; it SHALL raise a hazard instead.
REQ-023 stall SHALL equal id_valid AND (any REQ-022 hazard OR state==MC_WAIT).
REQ-024 issue SHALL equal id_valid AND NOT stall AND NOT flush.
REQ-025 The FSM SHALL have exactly two states, RUN and MC_WAIT, plus a 4-bit counter cnt.
REQ-026 In RUN, every edge SHALL shift WB<=MEM and MEM<=EX; EX SHALL load the ID fields if issue=1, else a bubble (valid=0).
REQ-027 Issue with id_is_mc=1 SHALL move the FSM to MC_WAIT with cnt=MC_LAT-1.
REQ-028 In MC_WAIT with cnt!=0: EX SHALL hold, MEM SHALL take a bubble, WB<=MEM, and cnt SHALL decrement.
REQ-029 In MC_WAIT with cnt==0: the FSM SHALL return to RUN and shift as in RUN with a bubble into EX, so the op occupies EX for exactly MC_LAT cycles.
REQ-030 busy SHALL equal state==MC_WAIT.
REQ-031 flush SHALL, at the next edge: set EX valid to 0, force RUN, clear cnt, and still shift EX's previous contents to nowhere while MEM and WB shift normally.
REQ-032 flush SHALL take priority over issue and over the MC_WAIT hold.
REQ-033 stall_cnt SHALL increment on each cycle with stall=1 and hold at 16'hFFFF.

Reset
REQ-034 While reset=1: all stage valid bits SHALL be 0, state SHALL be RUN, cnt SHALL be 0 and stall_cnt SHALL be 0; reset SHALL act without a clock edge.
REQ-035 After reset, outputs SHALL be fwd_sel=0, stall=0 and busy=0, and issue SHALL equal id_valid.
REQ-036 Reset asserted during MC_WAIT SHALL abandon the op with no residual stall.

Structure
REQ-037 The fwd_sel encodings (00/01/10/11) and state encodings SHALL be defined in the shared CPU defines include file.
REQ-038 A sub-module fwd_src_cmp (one source against three stages; outputs a 2-bit select and a hazard flag) SHALL be instantiated NUM_SRC times via generate.

Verification
REQ-039 Scenario: ALU writes r3, next instruction reads r3 -> fwd_sel=01, stall=0; one cycle later fwd_sel=10; two cycles later fwd_sel=11.
REQ-040 Scenario: load r5, then reader of r5 -> stall=1 for exactly 1 cycle, then fwd_sel=10 and issue=1.
REQ-041 Scenario: MC_LAT=4 op issued at cycle T -> busy=1 during T+1..T+4, stall=1 for a waiting reader, issue resumes at T+5.
REQ-042 Scenario: rs=0 matching a writer of r0, and id_rs_used=0 with a matching rs -> fwd_sel=00, stall=0.
REQ-043 Scenario: flush in MC_WAIT at cnt=2 -> busy=0 next cycle, and EX valid=0 with no forwarding from it.
REQ-044 Scenario: stall held for 70000 cycles -> stall_cnt=16'hFFFF; reset -> stall_cnt=0 asynchronously.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared encodings and stage-tracking record for the forwarding/hazard unit.
// Forward-select codes, FSM states and the per-stage flag record live here.
package fwd_hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_t;

  // Destination address is kept beside this record because its width is a module parameter.
  typedef struct packed {
    logic valid;
    logic wr_en;
    logic is_load;
    logic is_mc;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  function automatic logic stage_writes(input stage_t st);
    return st.valid && st.wr_en;
  endfunction

endpackage

// File: rtl/fwd_src_cmp.sv
// Compares one ID source operand against the EX/MEM/WB producers.
// Picks the youngest usable producer and flags an EX result that is not ready yet.
module fwd_src_cmp
  import fwd_hazard_unit_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic              used,
  input  stage_t            ex_f,
  input  logic [ADDR_W-1:0] ex_rd,
  input  stage_t            mem_f,
  input  logic [ADDR_W-1:0] mem_rd,
  input  stage_t            wb_f,
  input  logic [ADDR_W-1:0] wb_rd,
  output logic [1:0]        sel,
  output logic              hazard
);

  logic rs_live;
  logic ex_hit, mem_hit, wb_hit;
  logic unused_flags;

  // r0 is hardwired zero, so it never has a producer.
  assign rs_live = used && (rs != '0);
  assign ex_hit  = rs_live && stage_writes(ex_f)  && (ex_rd  == rs);
  assign mem_hit = rs_live && stage_writes(mem_f) && (mem_rd == rs);
  assign wb_hit  = rs_live && stage_writes(wb_f)  && (wb_rd  == rs);

  // Load and multi-cycle results do not exist while the op sits in EX.
  assign hazard = ex_hit && (ex_f.is_load || ex_f.is_mc);

  always_comb begin
    sel = FWD_RF;
    if (ex_hit && !hazard) sel = FWD_EX;
    else if (mem_hit)      sel = FWD_MEM;
    else if (wb_hit)       sel = FWD_WB;
  end

  assign unused_flags = ^{mem_f.is_load, mem_f.is_mc, wb_f.is_load, wb_f.is_mc};

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and issue control for a 5-stage pipe with multi-cycle EX ops.
// Tracks EX/MEM/WB destinations, picks bypass sources and stalls ID on unready results.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int MC_LAT  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [ADDR_W-1:0]         id_rd,
  input  logic                      id_wr_en,
  input  logic                      id_is_load,
  input  logic                      id_is_mc,
  input  logic                      flush,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      issue,
  output logic                      busy,
  output logic [15:0]               stall_cnt
);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  stage_t            ex_f, mem_f, wb_f;
  stage_t            ex_f_nxt, mem_f_nxt;
  logic [ADDR_W-1:0] ex_rd, mem_rd, wb_rd, ex_rd_nxt;
  logic [NUM_SRC-1:0] hazard;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_cmp #(.ADDR_W(ADDR_W)) u_cmp (
      .rs     (id_rs[s*ADDR_W +: ADDR_W]),
      .used   (id_rs_used[s]),
      .ex_f   (ex_f),
      .ex_rd  (ex_rd),
      .mem_f  (mem_f),
      .mem_rd (mem_rd),
      .wb_f   (wb_f),
      .wb_rd  (wb_rd),
      .sel    (fwd_sel[s*2 +: 2]),
      .hazard (hazard[s])
    );
  end

  assign busy  = (state == ST_MC_WAIT);
  assign stall = id_valid && ((|hazard) || busy);
  assign issue = id_valid && !stall && !flush;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ex_f_nxt  = ex_f;
    ex_rd_nxt = ex_rd;
    mem_f_nxt = ex_f;
    if (flush) begin
      // Killed EX op must not reach MEM either.
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
      ex_f_nxt  = STAGE_BUBBLE;
      mem_f_nxt = STAGE_BUBBLE;
    end else if (busy && cnt != 4'd0) begin
      cnt_nxt   = cnt - 4'd1;
      mem_f_nxt = STAGE_BUBBLE;
    end else begin
      // RUN, or the last MC_WAIT cycle releasing the op into MEM.
      state_nxt = ST_RUN;
      ex_f_nxt  = STAGE_BUBBLE;
      if (issue) begin
        ex_f_nxt.valid   = 1'b1;
        ex_f_nxt.wr_en   = id_wr_en;
        ex_f_nxt.is_load = id_is_load;
        ex_f_nxt.is_mc   = id_is_mc;
        ex_rd_nxt        = id_rd;
        if (id_is_mc) begin
          state_nxt = ST_MC_WAIT;
          cnt_nxt   = 4'(MC_LAT - 1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      cnt       <= '0;
      ex_f      <= STAGE_BUBBLE;
      mem_f     <= STAGE_BUBBLE;
      wb_f      <= STAGE_BUBBLE;
      ex_rd     <= '0;
      mem_rd    <= '0;
      wb_rd     <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ex_f   <= ex_f_nxt;
      ex_rd  <= ex_rd_nxt;
      mem_f  <= mem_f_nxt;
      mem_rd <= ex_rd;
      wb_f   <= mem_f;
      wb_rd  <= mem_rd;
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboarded bench for fwd_hazard_unit: a timeline model of in-flight instructions
// predicts each cycle's outputs, a negedge monitor pops and compares them.
module tb_fwd_hazard_unit;
  localparam int ADDR_W  = 5;
  localparam int NUM_SRC = 2;
  localparam int MC_LAT  = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      id_valid;
  logic [NUM_SRC*ADDR_W-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [ADDR_W-1:0]         id_rd;
  logic                      id_wr_en, id_is_load, id_is_mc, flush;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall, issue, busy;
  logic [15:0]               stall_cnt;

  fwd_hazard_unit #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .MC_LAT(MC_LAT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load), .id_is_mc(id_is_mc),
    .flush(flush), .fwd_sel(fwd_sel), .stall(stall), .issue(issue), .busy(busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // An instruction occupies EX over [ex_start, ex_end], MEM at ex_end+1, WB at ex_end+2.
  typedef struct {
    int rd; bit wr; bit ld; bit mc; int ex_start; int ex_end;
  } ins_t;
  typedef struct {
    logic [NUM_SRC*2-1:0] sel; bit chk_sel; bit stall; bit issue; bit busy; int scnt;
  } exp_t;

  ins_t inflight[$];
  exp_t sbq[$];
  exp_t me;
  int now = 0;
  int model_scnt = 0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  function automatic int stage_of(input ins_t r);
    if (r.ex_start <= now && now <= r.ex_end) return 1;
    if (now == r.ex_end + 1) return 2;
    if (now == r.ex_end + 2) return 3;
    return 0;
  endfunction

  task automatic step(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                      input int rd, input bit wr, input bit ld, input bit mc, input bit fl);
    exp_t e;
    ins_t n;
    bit haz, bsy;
    int best, stg, rsv;
    id_valid = v; id_rs[ADDR_W-1:0] = ADDR_W'(rs0); id_rs[2*ADDR_W-1:ADDR_W] = ADDR_W'(rs1);
    id_rs_used = used; id_rd = ADDR_W'(rd); id_wr_en = wr; id_is_load = ld; id_is_mc = mc;
    flush = fl;
    for (int i = inflight.size() - 1; i >= 0; i--)
      if (inflight[i].ex_end + 2 < now) inflight.delete(i);
    haz = 0; bsy = 0; e.sel = '0;
    foreach (inflight[i]) if (inflight[i].mc && stage_of(inflight[i]) == 1) bsy = 1;
    for (int s = 0; s < NUM_SRC; s++) begin
      best = 0;
      rsv  = (s == 0) ? rs0 : rs1;
      foreach (inflight[i]) begin
        stg = stage_of(inflight[i]);
        if (stg != 0 && inflight[i].wr && used[s] && rsv != 0 && inflight[i].rd == rsv) begin
          if (stg == 1 && (inflight[i].ld || inflight[i].mc)) haz = 1;
          else if (best == 0 || stg < best) best = stg;
        end
      end
      e.sel[s*2 +: 2] = 2'(best);  // 1=EX, 2=MEM, 3=WB map onto 01/10/11
    end
    e.stall   = v && (haz || bsy);
    e.issue   = v && !e.stall && !fl;
    e.busy    = bsy;
    e.chk_sel = !haz;
    e.scnt    = model_scnt;
    sbq.push_back(e);
    if (e.stall && model_scnt < 65535) model_scnt++;
    if (fl)
      for (int i = inflight.size() - 1; i >= 0; i--)
        if (stage_of(inflight[i]) == 1) inflight.delete(i);
    if (e.issue) begin
      n.rd = rd; n.wr = wr; n.ld = ld; n.mc = mc;
      n.ex_start = now + 1;
      n.ex_end   = now + (mc ? MC_LAT : 1);
      inflight.push_back(n);
    end
    now++;
  endtask

  task automatic cyc(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                     input int rd, input bit wr, input bit ld, input bit mc, input bit fl);
    @(posedge clk);
    #1;
    step(v, rs0, rs1, used, rd, wr, ld, mc, fl);
  endtask

  // Asserts reset mid-cycle, checks its effect before any edge, then releases it.
  task automatic reset_check(input string tag);
    @(negedge clk);
    #2;
    id_valid = 1'b1; flush = 1'b0; id_is_mc = 1'b0; id_is_load = 1'b0;
    id_rs = {5'd1, 5'd1}; id_rs_used = 2'b11;
    reset = 1'b1;
    #1;
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_scnt"},  32'(stall_cnt), 32'd0);
    chk({tag, "_fwd"},   32'(fwd_sel), 32'd0);
    chk({tag, "_issue"}, 32'(issue), 32'd1);
    id_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    inflight.delete();
    model_scnt = 0;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk("sb_stall", 32'(stall), 32'(me.stall));
      chk("sb_issue", 32'(issue), 32'(me.issue));
      chk("sb_busy",  32'(busy),  32'(me.busy));
      chk("sb_scnt",  32'(stall_cnt), 32'(me.scnt));
      if (me.chk_sel) chk("sb_fwd_sel", 32'(fwd_sel), 32'(me.sel));
    end
  end

  initial begin
    reset = 1'b1; id_valid = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_wr_en = 0; id_is_load = 0; id_is_mc = 0; flush = 0;
    reset_check("rst0");

    // ALU producer walks EX -> MEM -> WB
    cyc(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    cyc(1, 3, 0, 2'b01, 0, 0, 0, 0, 0); #1 chk("alu_ex", 32'(fwd_sel[1:0]), 32'h1);
    chk("alu_ex_stall", 32'(stall), 32'd0);
    cyc(1, 3, 0, 2'b01, 0, 0, 0, 0, 0); #1 chk("alu_mem", 32'(fwd_sel[1:0]), 32'h2);
    cyc(1, 3, 0, 2'b01, 0, 0, 0, 0, 0); #1 chk("alu_wb", 32'(fwd_sel[1:0]), 32'h3);

    // load-use: one stall, then bypass from MEM
    cyc(1, 0, 0, 2'b00, 5, 1, 1, 0, 0);
    cyc(1, 0, 5, 2'b10, 0, 0, 0, 0, 0); #1 chk("ld_stall", 32'(stall), 32'd1);
    cyc(1, 0, 5, 2'b10, 0, 0, 0, 0, 0); #1 chk("ld_go", 32'({stall, issue}), 32'b01);
    chk("ld_fwd", 32'(fwd_sel[3:2]), 32'h2);

    // multi-cycle op occupies EX for MC_LAT cycles
    cyc(1, 0, 0, 2'b00, 7, 1, 0, 1, 0); #1 chk("mc_issue", 32'(issue), 32'd1);
    for (int k = 0; k < MC_LAT; k++) begin
      cyc(1, 7, 0, 2'b01, 0, 0, 0, 0, 0); #1 chk("mc_wait", 32'({busy, stall}), 32'b11);
    end
    cyc(1, 7, 0, 2'b01, 0, 0, 0, 0, 0); #1 chk("mc_done", 32'({busy, issue}), 32'b01);
    chk("mc_fwd", 32'(fwd_sel[1:0]), 32'h2);

    // r0 and unused sources never forward
    cyc(1, 0, 0, 2'b00, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 2'b01, 9, 1, 0, 0, 0); #1 chk("r0_fwd", 32'({fwd_sel, stall}), 32'd0);
    cyc(1, 9, 9, 2'b00, 0, 0, 0, 0, 0); #1 chk("unused_fwd", 32'({fwd_sel, stall}), 32'd0);

    // flush during MC_WAIT with cnt=2
    cyc(1, 0, 0, 2'b00, 6, 1, 0, 1, 0);
    cyc(1, 6, 0, 2'b01, 0, 0, 0, 0, 0);
    cyc(1, 6, 0, 2'b01, 0, 0, 0, 0, 1); #1 chk("fl_busy", 32'({busy, issue}), 32'b10);
    cyc(1, 6, 0, 2'b01, 0, 0, 0, 0, 0); #1 chk("fl_after", 32'({busy, stall, fwd_sel}), 32'd0);

    // reset in the middle of a multi-cycle op
    cyc(1, 0, 0, 2'b00, 2, 1, 0, 1, 0);
    cyc(1, 2, 0, 2'b01, 0, 0, 0, 0, 0);
    reset_check("rst_mc");

    repeat (800) begin
      cyc($urandom_range(0, 99) < 85, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0);
    end

    // back-to-back multi-cycle ops stall 4 of every 5 cycles: enough to saturate
    repeat (83000) cyc(1, 0, 0, 2'b00, 1, 1, 0, 1, 0);
    #1 chk("scnt_sat", 32'(stall_cnt), 32'h0000FFFF);
    reset_check("rst_sat");
    cyc(1, 1, 1, 2'b11, 4, 1, 0, 0, 0);
    @(negedge clk);
    #1 chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
